// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent clock-enable generators on clk_in.
// Each channel has a runtime-programmable divide ratio and produces a
// one-cycle tick strobe and a near-50% duty square wave, both registered.
// A new ratio is held as pending and applied only at a period boundary,
// so the running period is never cut short.
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 27,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_CH-1:0]    ch_en_in,
  input  logic                 sync_in,
  input  logic                 cfg_valid_in,
  input  logic [CH_W-1:0]      cfg_ch_in,
  input  logic [CNT_WIDTH-1:0] cfg_div_in,
  output logic                 cfg_ready_out,
  output logic [NUM_CH-1:0]    pending_out,
  output logic [NUM_CH-1:0]    tick_out,
  output logic [NUM_CH-1:0]    clk_div_out
);

  // A ratio of zero is treated as one everywhere, including the reset value.
  localparam logic [CNT_WIDTH-1:0] RESET_DIV =
    (DEFAULT_DIV == 0) ? CNT_WIDTH'(1) : CNT_WIDTH'(DEFAULT_DIV);

  // True while the counter sits in the first ceil(div/2) cycles of the period.
  function automatic logic in_high_half(input logic [CNT_WIDTH-1:0] cnt,
                                        input logic [CNT_WIDTH-1:0] div);
    logic [CNT_WIDTH:0] half;
    half = ({1'b0, div} + {{CNT_WIDTH{1'b0}}, 1'b1}) >> 1;
    return ({1'b0, cnt} < half);
  endfunction

  logic [CNT_WIDTH-1:0] cnt_r  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_s  [NUM_CH];
  logic [CNT_WIDTH-1:0] div_r  [NUM_CH];
  logic [CNT_WIDTH-1:0] div_s  [NUM_CH];
  logic [CNT_WIDTH-1:0] pdiv_r [NUM_CH];
  logic [CNT_WIDTH-1:0] pdiv_s [NUM_CH];
  logic [NUM_CH-1:0]    run_r, run_s;
  logic [NUM_CH-1:0]    pend_r, pend_s;
  logic [NUM_CH-1:0]    tick_r, tick_s;
  logic [NUM_CH-1:0]    clk_div_r, clk_div_s;
  logic [NUM_CH-1:0]    apply_s;

  logic                 cfg_in_range_s;
  logic                 cfg_ready_s;
  logic                 cfg_hit_s;
  logic [CNT_WIDTH-1:0] cfg_div_norm_s;

  // Config handshake: ready unless in reset or the target already holds a pending ratio.
  always_comb begin
    cfg_in_range_s = (32'(cfg_ch_in) < 32'(NUM_CH));
    cfg_ready_s    = 1'b0;
    if (rst_in) begin
      cfg_ready_s = 1'b0;
    end else if (cfg_in_range_s) begin
      cfg_ready_s = !pend_r[cfg_ch_in];
    end else begin
      cfg_ready_s = 1'b1;
    end
    cfg_hit_s      = cfg_valid_in && cfg_ready_s && cfg_in_range_s;
    cfg_div_norm_s = (cfg_div_in == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : cfg_div_in;
  end

  // Per-channel next state: counter, ratio switch at period boundaries, registered outputs.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_s[i]     = cnt_r[i];
      div_s[i]     = div_r[i];
      pdiv_s[i]    = pdiv_r[i];
      run_s[i]     = run_r[i];
      pend_s[i]    = pend_r[i];
      apply_s[i]   = 1'b0;
      tick_s[i]    = 1'b0;
      clk_div_s[i] = 1'b0;

      if (!ch_en_in[i]) begin
        // Disabled: hold at zero; a pending ratio may take effect immediately.
        cnt_s[i]   = {CNT_WIDTH{1'b0}};
        run_s[i]   = 1'b0;
        apply_s[i] = pend_r[i];
      end else if (!run_r[i] || sync_in ||
                   (cnt_r[i] == div_r[i] - CNT_WIDTH'(1))) begin
        // Start, sync or wrap: next cycle is the first of a new period.
        cnt_s[i]   = {CNT_WIDTH{1'b0}};
        run_s[i]   = 1'b1;
        apply_s[i] = pend_r[i];
      end else begin
        cnt_s[i]   = cnt_r[i] + CNT_WIDTH'(1);
        run_s[i]   = 1'b1;
        apply_s[i] = 1'b0;
      end

      if (apply_s[i]) begin
        div_s[i]  = pdiv_r[i];
        pend_s[i] = 1'b0;
      end else begin
        div_s[i]  = div_r[i];
      end

      // An accept never coincides with an apply on the same channel (ready is low while pending).
      if (cfg_hit_s && (cfg_ch_in == CH_W'(i))) begin
        pend_s[i] = 1'b1;
        pdiv_s[i] = cfg_div_norm_s;
      end else begin
        pdiv_s[i] = pdiv_r[i];
      end

      if (ch_en_in[i]) begin
        tick_s[i]    = (cnt_s[i] == div_s[i] - CNT_WIDTH'(1));
        clk_div_s[i] = in_high_half(cnt_s[i], div_s[i]);
      end else begin
        tick_s[i]    = 1'b0;
        clk_div_s[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]  <= {CNT_WIDTH{1'b0}};
        div_r[i]  <= RESET_DIV;
        pdiv_r[i] <= RESET_DIV;
      end
      run_r     <= {NUM_CH{1'b0}};
      pend_r    <= {NUM_CH{1'b0}};
      tick_r    <= {NUM_CH{1'b0}};
      clk_div_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]  <= cnt_s[i];
        div_r[i]  <= div_s[i];
        pdiv_r[i] <= pdiv_s[i];
      end
      run_r     <= run_s;
      pend_r    <= pend_s;
      tick_r    <= tick_s;
      clk_div_r <= clk_div_s;
    end
  end

  assign cfg_ready_out = cfg_ready_s;
  assign pending_out   = pend_r;
  assign tick_out      = tick_r;
  assign clk_div_out   = clk_div_r;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: the driver pushes the expected
// per-cycle outputs from a phase-arithmetic reference model; a monitor pops
// and compares on the falling edge.
module tb_multi_clock_divider;
  localparam int NUM_CH      = 4;
  localparam int CNT_WIDTH   = 27;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [NUM_CH-1:0]    ch_en_in;
  logic                 sync_in;
  logic                 cfg_valid_in;
  logic [CH_W-1:0]      cfg_ch_in;
  logic [CNT_WIDTH-1:0] cfg_div_in;
  logic                 cfg_ready_out;
  logic [NUM_CH-1:0]    pending_out;
  logic [NUM_CH-1:0]    tick_out;
  logic [NUM_CH-1:0]    clk_div_out;

  always #5 clk_in = ~clk_in;

  multi_clock_divider #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ch_en_in(ch_en_in), .sync_in(sync_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ch_in(cfg_ch_in), .cfg_div_in(cfg_div_in),
    .cfg_ready_out(cfg_ready_out), .pending_out(pending_out),
    .tick_out(tick_out), .clk_div_out(clk_div_out)
  );

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clkd;
    logic [NUM_CH-1:0] pend;
    logic              rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel remembers the absolute cycle its current
  // period began and its ratio; outputs follow from (cycle - start) mod D.
  int m_d     [NUM_CH];
  int m_pdiv  [NUM_CH];
  int m_start [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_act   [NUM_CH];
  bit m_rst;
  int cyc;
  logic [NUM_CH-1:0] cur_en;

  task automatic chk(input string nm, input int c, input logic [NUM_CH-1:0] act,
                     input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, push this cycle's expectation, advance the model across the edge.
  task automatic drive(input logic rst, input logic [NUM_CH-1:0] en, input logic sync,
                       input logic cv, input logic [CH_W-1:0] cch,
                       input logic [CNT_WIDTH-1:0] cdiv, output bit acc);
    exp_t e;
    int   ph;
    @(posedge clk_in);
    #1;
    rst_in = rst; ch_en_in = en; sync_in = sync;
    cfg_valid_in = cv; cfg_ch_in = cch; cfg_div_in = cdiv;
    cur_en = en;

    e.cyc = cyc;
    e.rdy = !rst && !m_pend[cch];
    for (int i = 0; i < NUM_CH; i++) begin
      e.pend[i] = m_pend[i];
      if (!m_rst && m_act[i]) begin
        ph        = (cyc - m_start[i]) % m_d[i];
        e.tick[i] = (ph == m_d[i] - 1);
        e.clkd[i] = (ph < (m_d[i] + 1) / 2);
      end else begin
        e.tick[i] = 1'b0;
        e.clkd[i] = 1'b0;
      end
    end
    acc = cv && e.rdy;
    exp_q.push_back(e);

    if (rst) begin
      m_rst = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_d[i] = DEFAULT_DIV; m_pend[i] = 1'b0; m_act[i] = 1'b0;
      end
    end else begin
      m_rst = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bit boundary;
        if (!en[i]) begin
          m_act[i] = 1'b0;
          boundary = 1'b1;
        end else if (!m_act[i]) begin
          m_act[i] = 1'b1;
          boundary = 1'b1;
        end else begin
          boundary = sync || (((cyc - m_start[i]) % m_d[i]) == m_d[i] - 1);
        end
        if (boundary) begin
          m_start[i] = cyc + 1;
          if (m_pend[i]) begin
            m_d[i]    = m_pdiv[i];
            m_pend[i] = 1'b0;
          end
        end
      end
      if (acc) begin
        m_pend[cch] = 1'b1;
        m_pdiv[cch] = (cdiv == '0) ? 1 : int'(cdiv);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) drive(1'b0, cur_en, 1'b0, 1'b0, 2'd0, 27'd0, acc);
  endtask

  // Hold a config request until it is accepted (bounded).
  task automatic cfg(input logic [CH_W-1:0] ch, input int d);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 60 && !acc; t++)
      drive(1'b0, cur_en, 1'b0, 1'b1, ch, CNT_WIDTH'(d), acc);
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick_out",      e.cyc, tick_out,    e.tick);
        chk("clk_div_out",   e.cyc, clk_div_out, e.clkd);
        chk("pending_out",   e.cyc, pending_out, e.pend);
        chk("cfg_ready_out", e.cyc, {{(NUM_CH-1){1'b0}}, cfg_ready_out},
            {{(NUM_CH-1){1'b0}}, e.rdy});
      end
    end
  end

  initial begin
    bit acc;
    rst_in = 1'b1; ch_en_in = '1; sync_in = 1'b0;
    cfg_valid_in = 1'b0; cfg_ch_in = '0; cfg_div_in = '0;
    cur_en = '1; m_rst = 1'b1; cyc = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_d[i] = DEFAULT_DIV; m_pdiv[i] = DEFAULT_DIV; m_start[i] = 0;
      m_pend[i] = 1'b0; m_act[i] = 1'b0;
    end

    // Reset then default ratio on all channels
    for (int t = 0; t < 10; t++) drive(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 27'd0, acc);
    idle(6);
    // ch1 D=5 mid-period
    cfg(2'd1, 5);
    idle(20);
    // ch2 D=0 then D=1
    cfg(2'd2, 0);
    idle(12);
    cfg(2'd2, 1);
    idle(12);
    // back-to-back writes to ch3
    cfg(2'd3, 8);
    cfg(2'd3, 3);
    idle(20);
    // ch0 D=4, ch1 D=6, then sync
    cfg(2'd0, 4);
    cfg(2'd1, 6);
    idle(15);
    drive(1'b0, cur_en, 1'b1, 1'b0, 2'd0, 27'd0, acc);
    idle(30);
    // accept coincident with sync
    drive(1'b0, cur_en, 1'b1, 1'b1, 2'd2, 27'd7, acc);
    idle(20);
    // pending write then reset
    cfg(2'd1, 10);
    drive(1'b1, cur_en, 1'b0, 1'b0, 2'd0, 27'd0, acc);
    idle(20);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      logic [NUM_CH-1:0] en;
      logic              r, s, v;
      en = cur_en;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(39, 0) == 0) en[i] = ~en[i];
      r = ($urandom_range(199, 0) == 0);
      s = ($urandom_range(29, 0) == 0);
      v = ($urandom_range(3, 0) == 0);
      drive(r, en, s, v, CH_W'($urandom_range(NUM_CH - 1, 0)),
            CNT_WIDTH'($urandom_range(9, 0)), acc);
    end
    idle(2);

    for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk_in);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
